// File: rtl/mem_port_arbiter.sv
// Data-port arbiter: CPU MEM stage vs IO/DMA engine, CPU-priority with
// starvation guard, bounded DMA burst lock, address-map checks and registered reads.
module mem_port_arbiter #(
    parameter int WIDTH        = 32,
    parameter int RAMSIZE      = 1024,
    parameter int NSEG         = 6,
    parameter int MAXBURST     = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wd,
    output logic             cpu_gnt,
    output logic             cpu_stall,
    output logic             cpu_rvalid,
    output logic [WIDTH-1:0] cpu_rdata,
    input  logic             dma_req,
    input  logic             dma_we,
    input  logic [WIDTH-1:0] dma_addr,
    input  logic [WIDTH-1:0] dma_wd,
    output logic             dma_gnt,
    output logic             dma_rvalid,
    output logic [WIDTH-1:0] dma_rdata,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd,
    output logic             err
);

    localparam int BW = $clog2(MAXBURST + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [BW-1:0] BMAX = BW'(MAXBURST);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_LIMIT);
    localparam logic [WIDTH-1:0] RAM_END = WIDTH'(RAMSIZE * NSEG);
    localparam logic [WIDTH-1:0] IO_ADDR = WIDTH'(RAMSIZE * 7);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CPU,
        S_DMA
    } state_e;

    state_e           state_q, state_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             cpu_rvalid_q, cpu_rvalid_d;
    logic             dma_rvalid_q, dma_rvalid_d;
    logic [WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [WIDTH-1:0] dma_rdata_q, dma_rdata_d;
    logic             err_q, err_d;

    logic             lock;
    logic             starved;
    logic             granted;
    logic             sel_we;
    logic [WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0] sel_wd;
    logic             in_ram;
    logic             legal;

    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        lock    = (state_q == S_DMA) && dma_req && (burst_q < BMAX);
        starved = dma_req && (starve_q == SMAX);
        if (!rst) begin
            cpu_gnt = 1'b0;
        end else if (lock) begin
            dma_gnt = 1'b1;
        end else if (cpu_req && !starved) begin
            cpu_gnt = 1'b1;
        end else if (dma_req) begin
            dma_gnt = 1'b1;
        end
    end

    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_wd   = '0;
        if (cpu_gnt) begin
            sel_we   = cpu_we;
            sel_addr = cpu_addr;
            sel_wd   = cpu_wd;
        end else if (dma_gnt) begin
            sel_we   = dma_we;
            sel_addr = dma_addr;
            sel_wd   = dma_wd;
        end
    end

    // IO status word is readable but never writable
    assign granted   = cpu_gnt | dma_gnt;
    assign in_ram    = sel_addr < RAM_END;
    assign legal     = in_ram | ((sel_addr == IO_ADDR) & ~sel_we);
    assign mem_we    = granted & sel_we & in_ram;
    assign mem_addr  = sel_addr;
    assign mem_wd    = sel_wd;
    assign cpu_stall = cpu_req & ~cpu_gnt;

    always_comb begin
        state_d      = S_IDLE;
        burst_d      = '0;
        starve_d     = starve_q;
        cpu_rvalid_d = cpu_gnt & ~cpu_we;
        dma_rvalid_d = dma_gnt & ~dma_we;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        err_d        = granted & ~legal;
        if (dma_gnt) begin
            state_d  = S_DMA;
            starve_d = '0;
            burst_d  = (burst_q == BMAX) ? burst_q : burst_q + 1'b1;
        end else if (cpu_gnt) begin
            state_d = S_CPU;
            if (dma_req && starve_q != SMAX) begin
                starve_d = starve_q + 1'b1;
            end
        end
        if (cpu_rvalid_d) begin
            cpu_rdata_d = mem_rd;
        end
        if (dma_rvalid_d) begin
            dma_rdata_d = mem_rd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            burst_q      <= '0;
            starve_q     <= '0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_q      <= burst_d;
            starve_q     <= starve_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dma_rvalid_q <= dma_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
            err_q        <= err_d;
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign dma_rvalid = dma_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dma_rdata  = dma_rdata_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed table, hand sequences for the
// burst/starvation/reset corners, and random traffic against a rule-level model.
module tb_mem_port_arbiter;

    localparam int MAXB = 8;
    localparam int STV  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wd, dma_addr, dma_wd;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        mem_we, err;
    logic [31:0] mem_addr, mem_wd, mem_rd;

    logic [31:0] mem [0:8191];

    int checks = 0;
    int failures = 0;

    // model state: last owner, DMA run length, contested CPU wins
    int m_last, m_run, m_streak, m_g;
    logic        e_crv, e_drv, e_err;
    logic [31:0] e_crd, e_drd;
    logic        s_cg, s_dg, s_stall, s_mwe, s_crv, s_drv, s_err;
    logic [31:0] s_crd, s_drd;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wd(dma_wd),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .dma_rdata(dma_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd),
        .err(err)
    );

    assign mem_rd = mem[mem_addr[12:0]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[12:0]] <= mem_wd;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h",
                     name, $time, act, exp);
        end
    endtask

    function automatic bit illegal(input logic [31:0] a, input logic w);
        return !((a < 32'd6144) || (a == 32'd7168 && !w));
    endfunction

    function automatic int model_grant();
        if (!rst) return 0;
        if (m_last == 2 && dma_req && m_run < MAXB) return 2;
        if (cpu_req && !(dma_req && m_streak >= STV)) return 1;
        if (dma_req) return 2;
        return 0;
    endfunction

    task automatic cycle();
        int g;
        logic [31:0] ea, ew;
        logic        ewe;
        @(negedge clk);
        if (!rst) begin
            m_last = 0; m_run = 0; m_streak = 0;
            e_crv = 0; e_drv = 0; e_err = 0;
            e_crd = 0; e_drd = 0;
        end
        chk("cpu_rvalid", cpu_rvalid, e_crv);
        chk("cpu_rdata", cpu_rdata, e_crd);
        chk("dma_rvalid", dma_rvalid, e_drv);
        chk("dma_rdata", dma_rdata, e_drd);
        chk("err", err, e_err);
        g = model_grant();
        s_cg = cpu_gnt; s_dg = dma_gnt; s_stall = cpu_stall;
        s_mwe = mem_we; s_crv = cpu_rvalid; s_drv = dma_rvalid;
        s_crd = cpu_rdata; s_drd = dma_rdata; s_err = err;
        chk("cpu_gnt", cpu_gnt, g == 1);
        chk("dma_gnt", dma_gnt, g == 2);
        chk("onehot", cpu_gnt & dma_gnt, 0);
        chk("cpu_stall", cpu_stall, cpu_req && g != 1);
        ea = 0; ew = 0; ewe = 0;
        if (g == 1) begin ea = cpu_addr; ew = cpu_wd; ewe = cpu_we; end
        if (g == 2) begin ea = dma_addr; ew = dma_wd; ewe = dma_we; end
        chk("mem_addr", mem_addr, ea);
        chk("mem_wd", mem_wd, ew);
        chk("mem_we", mem_we, g != 0 && ewe && ea < 32'd6144);
        e_crv = (g == 1) && !cpu_we;
        e_drv = (g == 2) && !dma_we;
        if (e_crv) e_crd = mem[cpu_addr[12:0]];
        if (e_drv) e_drd = mem[dma_addr[12:0]];
        e_err = (g != 0) && illegal(ea, ewe);
        if (g == 2) begin
            m_run = (m_run < MAXB) ? m_run + 1 : MAXB;
            m_streak = 0;
        end else begin
            m_run = 0;
            if (g == 1 && dma_req && m_streak < STV) m_streak++;
        end
        m_last = g;
        m_g = g;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wd = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wd = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        idle_in();
        cycle();
        cycle();
        rst = 1;
    endtask

    function automatic logic [31:0] rnd_addr();
        case ($urandom_range(0, 9))
            7: return 32'd6143;
            8: return $urandom_range(0, 1) ? 32'd6144 : 32'd7168;
            9: return $urandom_range(0, 1) ? 32'd7169 : 32'hFFFF_FFF0;
            default: return 32'($urandom_range(0, 63));
        endcase
    endfunction

    typedef struct {
        logic        creq, cwe;
        logic [31:0] caddr, cwd;
        logic        dreq, dwe;
        logic [31:0] daddr, dwd;
        logic        cg, dg, mwe, crv;
        logic [31:0] crd;
        logic        drv, er;
    } vec_t;

    vec_t tbl [11];

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 32'h1000_0000 | i;
        tbl[0]  = '{1'b1, 1'b1, 32'h10, 32'hDEAD, 1'b0, 1'b0, 0, 0,
                    1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 0, 0,
                    1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 0,
                    1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 32'd6144, 32'h1, 1'b0, 1'b0, 0, 0,
                    1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 32'd7168, 32'h2, 1'b0, 1'b0, 0, 0,
                    1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 32'd7168, 32'h0, 1'b0, 1'b0, 0, 0,
                    1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 0,
                    1'b0, 1'b0, 1'b0, 1'b1, 32'h1000_1C00, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 0,
                    1'b0, 1'b1, 1'b0, 1'b0, 32'h1000_1C00, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h30, 0,
                    1'b0, 1'b1, 1'b0, 1'b0, 32'h1000_1C00, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 0, 0,
                    1'b1, 1'b0, 1'b0, 1'b0, 32'h1000_1C00, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 0,
                    1'b0, 1'b0, 1'b0, 1'b1, 32'h1000_0020, 1'b0, 1'b0};

        m_last = 0; m_run = 0; m_streak = 0; m_g = 0;
        e_crv = 0; e_drv = 0; e_err = 0; e_crd = 0; e_drd = 0;
        idle_in();
        rst = 1;
        #3 rst = 0;

        // reset held with both requesting
        cpu_req = 1; dma_req = 1; cpu_we = 1; dma_we = 1;
        repeat (3) begin
            cycle();
            chk("rst_gnt", {s_cg, s_dg, s_mwe}, 0);
            chk("rst_regs", {s_crv, s_drv, s_err}, 0);
            chk("rst_rdata", s_crd | s_drd, 0);
        end
        rst = 1;
        idle_in();

        foreach (tbl[i]) begin
            cpu_req = tbl[i].creq; cpu_we = tbl[i].cwe;
            cpu_addr = tbl[i].caddr; cpu_wd = tbl[i].cwd;
            dma_req = tbl[i].dreq; dma_we = tbl[i].dwe;
            dma_addr = tbl[i].daddr; dma_wd = tbl[i].dwd;
            cycle();
            chk($sformatf("tbl%0d_gnt", i), {s_cg, s_dg},
                {tbl[i].cg, tbl[i].dg});
            chk($sformatf("tbl%0d_mwe", i), s_mwe, tbl[i].mwe);
            chk($sformatf("tbl%0d_crv", i), s_crv, tbl[i].crv);
            chk($sformatf("tbl%0d_crd", i), s_crd, tbl[i].crd);
            chk($sformatf("tbl%0d_drv", i), s_drv, tbl[i].drv);
            chk($sformatf("tbl%0d_err", i), s_err, tbl[i].er);
        end

        // both held high: CPU x4, DMA x8 repeating
        do_reset();
        cpu_req = 1; dma_req = 1;
        for (int k = 0; k < 36; k++) begin
            cpu_addr = k; dma_addr = k + 100;
            cycle();
            chk($sformatf("rr%0d", k), {s_cg, s_dg},
                (k % 12 < 4) ? 2'b10 : 2'b01);
        end

        // DMA burst, CPU arrives at 3rd grant
        do_reset();
        dma_req = 1;
        for (int k = 0; k < 9; k++) begin
            if (k == 2) cpu_req = 1;
            dma_addr = k;
            cycle();
            chk($sformatf("burst%0d_gnt", k), {s_cg, s_dg},
                (k < 8) ? 2'b01 : 2'b10);
            chk($sformatf("burst%0d_stall", k), s_stall, k >= 2 && k < 8);
        end
        idle_in();

        // reset between a DMA read grant and its rvalid
        do_reset();
        dma_req = 1; dma_addr = 32'h10;
        cycle();
        chk("rstrd_gnt", s_dg, 1);
        rst = 0;
        idle_in();
        cycle();
        chk("rstrd_rvalid", s_drv, 0);
        chk("rstrd_rdata", s_drd, 0);
        rst = 1;
        cpu_req = 1; dma_req = 1;
        cycle();
        chk("rstrd_resume", {s_cg, s_dg}, 2'b10);
        idle_in();
        cycle();

        // random traffic; requests hold until granted
        for (int n = 0; n < 3000; n++) begin
            if (!(cpu_req && m_g != 1)) begin
                cpu_req = ($urandom_range(0, 3) != 0);
                cpu_we = $urandom_range(0, 1);
                cpu_addr = rnd_addr();
                cpu_wd = $urandom;
            end
            if (!(dma_req && m_g != 2)) begin
                dma_req = ($urandom_range(0, 2) != 0);
                dma_we = $urandom_range(0, 1);
                dma_addr = rnd_addr();
                dma_wd = $urandom;
            end
            if ($urandom_range(0, 499) == 0) rst = 0;
            else rst = 1;
            cycle();
        end
        rst = 1;
        idle_in();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
